// File: rtl/cdu_pkg.sv
// Shared types and constants for the CDU counter-pulse scheduler.
package cdu_pkg;

    localparam int CHAN_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DRIVE
    } state_t;

    // Magnitude limit of a signed pending accumulator of width w.
    function automatic int pend_limit(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/cdu_count_scheduler_if.sv
// Strobe, request and pulse signals between the counter logic, the timing generator and the AGC.
interface cdu_count_scheduler_if
    import cdu_pkg::*;
#(
    parameter int NCHAN = 5
) ();

    logic              faz1;
    logic              faz2;
    logic              faz3;
    logic              faz4;
    logic              agc_busy;
    logic [NCHAN-1:0]  cnt_up;
    logic [NCHAN-1:0]  cnt_dn;
    logic              clr_err;
    logic              pinc;
    logic              minc;
    logic [CHAN_W-1:0] chan;
    logic [NCHAN-1:0]  ovf;
    logic              phase_err;

    modport master (
        output faz1, faz2, faz3, faz4, agc_busy, cnt_up, cnt_dn, clr_err,
        input  pinc, minc, chan, ovf, phase_err
    );

    modport slave (
        input  faz1, faz2, faz3, faz4, agc_busy, cnt_up, cnt_dn, clr_err,
        output pinc, minc, chan, ovf, phase_err
    );

endinterface

// File: rtl/cdu_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr, wrapping at NCHAN.
module cdu_rr_arbiter
    import cdu_pkg::*;
#(
    parameter int NCHAN = 5
) (
    input  logic [NCHAN-1:0]  req,
    input  logic [CHAN_W-1:0] ptr,
    output logic [CHAN_W-1:0] grant,
    output logic              valid
);

    always_comb begin
        int idx;
        logic [CHAN_W-1:0] sel;
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (which would infer a latch).
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        sel   = '0;
        // Scanning from the far end back to ptr leaves the nearest hit as the final assignment.
        for (int i = NCHAN - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NCHAN) idx = idx - NCHAN;
            sel = CHAN_W'(idx);
            if (req[sel]) begin
                grant = sel;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdu_count_scheduler.sv
// Counter-pulse scheduler: per-channel net-count accumulators shared round-robin onto
// one PINC/MINC slot per FAZ1-FAZ4 digital cycle, with sticky overflow and phase-error flags.
module cdu_count_scheduler
    import cdu_pkg::*;
#(
    parameter int NCHAN  = 5,
    parameter int PEND_W = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    cdu_count_scheduler_if.slave bus
);

    localparam int SUM_W = PEND_W + 2;
    localparam logic signed [SUM_W-1:0] LIM_POS = SUM_W'(pend_limit(PEND_W));
    localparam logic signed [SUM_W-1:0] LIM_NEG = -LIM_POS;
    localparam logic signed [SUM_W-1:0] ONE     = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] ZERO    = '0;

    state_t                   state, state_nxt;
    logic [CHAN_W-1:0]        grant, grant_nxt, rr_ptr, arb_grant, chan_q;
    logic                     dir_up, dir_nxt, arb_valid;
    logic                     pinc_q, minc_q, phase_err_q, err_set, served;
    logic [NCHAN-1:0]         ovf_q, ovf_set, req, neg;
    logic signed [PEND_W-1:0] pending  [NCHAN];
    logic signed [PEND_W-1:0] pend_nxt [NCHAN];
    logic [3:0]               strobes;
    logic                     multi;

    assign strobes = {bus.faz4, bus.faz3, bus.faz2, bus.faz1};
    assign multi   = $countones(strobes) > 1;

    cdu_rr_arbiter #(.NCHAN(NCHAN)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    for (genvar c = 0; c < NCHAN; c++) begin : g_acc
        logic signed [SUM_W-1:0]  sum, adj;
        logic signed [PEND_W-1:0] nxt;
        logic                     hit;

        always_comb begin
            adj = ZERO;
            if (served && grant == CHAN_W'(c)) adj = dir_up ? -ONE : ONE;
            sum = $signed({{2{pending[c][PEND_W-1]}}, pending[c]})
                + (bus.cnt_up[c] ? ONE : ZERO) - (bus.cnt_dn[c] ? ONE : ZERO) + adj;
            nxt = sum[PEND_W-1:0];
            hit = 1'b0;
            if (sum > LIM_POS) begin
                nxt = LIM_POS[PEND_W-1:0];
                hit = 1'b1;
            end else if (sum < LIM_NEG) begin
                nxt = LIM_NEG[PEND_W-1:0];
                hit = 1'b1;
            end
        end

        assign pend_nxt[c] = nxt;
        assign ovf_set[c]  = hit;
        assign req[c]      = pending[c] != '0;
        assign neg[c]      = pending[c][PEND_W-1];
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        dir_nxt   = dir_up;
        err_set   = 1'b0;
        served    = 1'b0;
        unique case (state)
            IDLE: begin
                if (multi) begin
                    err_set = 1'b1;
                end else if (bus.faz1 && !bus.agc_busy && arb_valid) begin
                    state_nxt = ARMED;
                    grant_nxt = arb_grant;
                    dir_nxt   = !neg[arb_grant];
                end
            end
            ARMED: begin
                if (multi || bus.faz1 || bus.faz4) begin
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                end else if (bus.faz2) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (multi || bus.faz1 || bus.faz2) begin
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                end else if (bus.faz4) begin
                    state_nxt = IDLE;
                    served    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            dir_up      <= 1'b0;
            rr_ptr      <= '0;
            pinc_q      <= 1'b0;
            minc_q      <= 1'b0;
            chan_q      <= '0;
            ovf_q       <= '0;
            phase_err_q <= 1'b0;
            // NOTE: this small register array is reset because its cleared value is architecturally visible; large RAM-style arrays would not be.
            for (int c = 0; c < NCHAN; c++) pending[c] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state       <= state_nxt;
            grant       <= grant_nxt;
            dir_up      <= dir_nxt;
            pinc_q      <= (state_nxt == DRIVE) && dir_nxt;
            minc_q      <= (state_nxt == DRIVE) && !dir_nxt;
            chan_q      <= (state_nxt == DRIVE) ? grant_nxt : '0;
            ovf_q       <= ovf_set | (bus.clr_err ? '0 : ovf_q);
            phase_err_q <= err_set | (phase_err_q & ~bus.clr_err);
            if (served) rr_ptr <= (grant == CHAN_W'(NCHAN - 1)) ? '0 : grant + CHAN_W'(1);
            for (int c = 0; c < NCHAN; c++) pending[c] <= pend_nxt[c];
        end
    end

    assign bus.pinc      = pinc_q;
    assign bus.minc      = minc_q;
    assign bus.chan      = chan_q;
    assign bus.ovf       = ovf_q;
    assign bus.phase_err = phase_err_q;

endmodule
